// File: rtl/afifo_wr_arbiter.sv
// Burst-granular round-robin arbiter for the shared async-FIFO write port (write-clock domain only).
// Define CONVKING_ARB_REQ0_PRIO_EN to give requester 0 absolute priority over the round-robin.
module afifo_wr_arbiter #(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = 64,
  parameter int  LEN_W   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [ID_W-1:0]           grant_id,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  input  logic [NUM_REQ-1:0]        src_vld,
  output logic [NUM_REQ-1:0]        src_rdy,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  input  logic                      fifo_wr_vld,
  output logic [NUM_REQ-1:0]        burst_done,
  output logic                      busy,
  output logic                      dbg_state,
  output logic [ID_W-1:0]           dbg_rr_ptr
);

  // Handshakes: a beat moves on src_vld[g] & src_rdy[g], which is the same cycle as
  // fifo_wr_en & fifo_wr_vld; neither side may make its valid depend on the other's ready.

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]     gid, gid_nxt;
  logic [NUM_REQ-1:0]  grant, grant_nxt;
  logic [NUM_REQ-1:0]  done, done_nxt;
  logic [LEN_W-1:0]    beat_cnt, beat_cnt_nxt;
  logic                prio_win, prio_win_nxt;

  logic                found;
  logic                win_prio;
  logic [ID_W-1:0]     winner;
  logic [ID_W:0]       sum;
  logic [ID_W-1:0]     cand;
  logic                accept;

  // Upward search from rr_ptr; sum stays below 2*NUM_REQ so one subtraction wraps it.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_prio = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef CONVKING_ARB_REQ0_PRIO_EN
    if (req_valid[0]) begin
      found    = 1'b1;
      winner   = '0;
      win_prio = 1'b1;
    end
`endif
  end

  assign accept = (state == BURST) && src_vld[gid] && fifo_wr_vld;

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    gid_nxt      = gid;
    grant_nxt    = grant;
    beat_cnt_nxt = beat_cnt;
    prio_win_nxt = prio_win;
    done_nxt     = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          gid_nxt           = winner;
          beat_cnt_nxt      = req_len[winner*LEN_W +: LEN_W];
          prio_win_nxt      = win_prio;
          state_nxt         = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          if (beat_cnt == '0) begin
            grant_nxt     = '0;
            done_nxt[gid] = 1'b1;
            // A priority win by requester 0 must not disturb the others' rotation.
            if (!prio_win) begin
              rr_ptr_nxt = (gid == ID_W'(NUM_REQ-1)) ? '0 : gid + 1'b1;
            end
            state_nxt = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gid      <= '0;
      grant    <= '0;
      done     <= '0;
      beat_cnt <= '0;
      prio_win <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      gid      <= gid_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      beat_cnt <= beat_cnt_nxt;
      prio_win <= prio_win_nxt;
    end
  end

  // Zero-latency data path: pure mux from the granted source.
  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    src_rdy      = '0;
    if (state == BURST) begin
      fifo_wr_en   = src_vld[gid];
      fifo_wr_data = src_data[gid*DATA_W +: DATA_W];
      src_rdy[gid] = fifo_wr_vld;
    end
  end

  assign req_grant  = grant;
  assign grant_id   = gid;
  assign burst_done = done;
  assign busy       = (state == BURST);
  assign dbg_state  = (state == BURST);
  assign dbg_rr_ptr = rr_ptr;

  a_grant_onehot0: assert property (@(posedge wr_clk) disable iff (wr_rst) $onehot0(req_grant));
  a_busy_grant:    assert property (@(posedge wr_clk) disable iff (wr_rst) busy == (|req_grant));
  a_rdy_in_grant:  assert property (@(posedge wr_clk) disable iff (wr_rst) (src_rdy & ~req_grant) == '0);
  a_en_busy:       assert property (@(posedge wr_clk) disable iff (wr_rst) fifo_wr_en |-> busy);

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter: transaction-level reference model, directed scenarios, random traffic.
// Honours CONVKING_ARB_REQ0_PRIO_EN the same way the design does.
module tb_afifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int IW = 2;

  // clock / reset
  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  always #5 wr_clk = ~wr_clk;

  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_grant;
  logic [IW-1:0]   grant_id;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_vld;
  logic [N-1:0]    src_rdy;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_vld;
  logic [N-1:0]    burst_done;
  logic            busy;
  logic            dbg_state;
  logic [IW-1:0]   dbg_rr_ptr;

  afifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst),
    .req_valid(req_valid), .req_len(req_len),
    .req_grant(req_grant), .grant_id(grant_id),
    .src_data(src_data), .src_vld(src_vld), .src_rdy(src_rdy),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_vld(fifo_wr_vld),
    .burst_done(burst_done), .busy(busy),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  int total = 0;
  int bad   = 0;

  // reference model: owner of the port (-1 = nobody), beats still owed, rotation start
  int       m_owner = -1;
  int       m_left  = 0;
  int       m_last  = 0;
  int       m_rr    = 0;
  bit       m_prio  = 1'b0;
  logic [N-1:0] m_done = '0;
  int       seq[N];

  // observations of the DUT
  int           beats    = 0;
  int           done_cnt = 0;
  logic [N-1:0] done_or  = '0;
  int           glog[$];
  int           gcyc[$];
  int           cyc      = 0;
  bit           prev_busy = 1'b0;
  bit           skip     = 1'b1;
  logic [15:0]  exp_q[$];
  int           bl_cnt   = 0;
  bit           pend[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    int w;
    w = -1;
`ifdef CONVKING_ARB_REQ0_PRIO_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
    end
    return w;
  endfunction

  // one clock cycle: inputs already applied after a negedge; compare, then advance the model
  task automatic step();
    logic [N-1:0]  e_grant, e_rdy;
    logic          e_en;
    logic [DW-1:0] e_data;
    int            w;
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = {8'(i), 56'(seq[i])};
    #1;
    if (!skip) begin
      e_grant = '0; e_rdy = '0; e_en = 1'b0; e_data = '0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_rdy[m_owner]   = fifo_wr_vld;
        e_en             = src_vld[m_owner];
        e_data           = src_data[m_owner*DW +: DW];
      end
      chk("req_grant", req_grant, e_grant);
      chk("grant_id", grant_id, m_last);
      chk("src_rdy", src_rdy, e_rdy);
      chk("fifo_wr_en", fifo_wr_en, e_en);
      chk("fifo_wr_data", fifo_wr_data, e_data);
      chk("burst_done", burst_done, m_done);
      chk("busy", busy, m_owner >= 0);
      chk("dbg_state", dbg_state, m_owner >= 0);
      chk("rr_ptr", dbg_rr_ptr, m_rr);
      if (burst_done != '0) begin
        done_cnt++;
        done_or |= burst_done;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL burst_len: got unexpected burst_done %0h, required none", burst_done);
        end else begin
          chk("burst_len", bl_cnt, exp_q.pop_front());
        end
        bl_cnt = 0;
      end
      if (fifo_wr_en && fifo_wr_vld) begin
        beats++;
        bl_cnt++;
      end
      if (busy && !prev_busy) begin
        glog.push_back(grant_id);
        gcyc.push_back(cyc);
      end
      prev_busy = busy;
    end
    if (wr_rst) begin
      m_owner = -1; m_left = 0; m_last = 0; m_rr = 0; m_prio = 1'b0; m_done = '0;
      exp_q.delete();
      bl_cnt = 0;
    end else begin
      m_done = '0;
      if (m_owner < 0) begin
        w = pick();
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
          m_left  = req_len[w*LW +: LW] + 1;
`ifdef CONVKING_ARB_REQ0_PRIO_EN
          m_prio  = (w == 0);
`else
          m_prio  = 1'b0;
`endif
          exp_q.push_back(16'(m_left));
        end
      end else if (src_vld[m_owner] && fifo_wr_vld) begin
        seq[m_owner]++;
        m_left--;
        if (m_left == 0) begin
          m_done[m_owner] = 1'b1;
          if (!m_prio) m_rr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    @(posedge wr_clk);
    @(negedge wr_clk);
    cyc++;
  endtask

  task automatic run_until_idle(input int cap, input string name);
    int n;
    n = 0;
    while ((m_owner >= 0 || m_done != '0) && n < cap) begin
      step();
      n++;
    end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic reset_dut();
    wr_rst = 1'b1;
    req_valid = '0;
    src_vld = '0;
    fifo_wr_vld = 1'b0;
    step();
    wr_rst = 1'b0;
  endtask

  initial begin
    int exp_ord[5];
    int b0;
    req_valid = '0; req_len = '0; src_vld = '0; fifo_wr_vld = 1'b0; src_data = '0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; pend[i] = 1'b0; end

    // reset: first cycle has no defined prior state to compare
    wr_rst = 1'b1;
    step();
    skip = 1'b0;
    step();
    wr_rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", req_grant, 4'b0000);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_rr", dbg_rr_ptr, 2'd0);
    chk("rst_done", burst_done, 4'b0000);

    // single burst of 4 from source 1
    req_valid = 4'b0010; req_len[1*LW +: LW] = 8'd3; src_vld = '1; fifo_wr_vld = 1'b1;
    beats = 0; done_cnt = 0; done_or = '0;
    step();
    req_valid = '0;
    chk("single_grant", req_grant, 4'b0010);
    run_until_idle(20, "single");
    chk("single_beats", beats, 4);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_done_id", done_or, 4'b0010);

    // round-robin from reset, all sources pending with 1-beat bursts
    reset_dut();
    req_valid = '1; req_len = '0; src_vld = '1; fifo_wr_vld = 1'b1;
    glog.delete(); gcyc.delete();
    repeat (10) step();
    req_valid = '0;
    run_until_idle(10, "rr");
`ifdef CONVKING_ARB_REQ0_PRIO_EN
    exp_ord = '{0, 0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    chk("rr_grants", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) chk($sformatf("rr_order%0d", k), glog[k], exp_ord[k]);
    for (int k = 0; k < 4 && k + 1 < gcyc.size(); k++) chk($sformatf("rr_gap%0d", k), gcyc[k+1] - gcyc[k], 2);

    // backpressure: 8-beat burst, FIFO full for 5 cycles after beat 3
    req_valid = 4'b0100; req_len[2*LW +: LW] = 8'd7; src_vld = '1; fifo_wr_vld = 1'b1;
    beats = 0;
    step();
    req_valid = '0;
    repeat (3) step();
    fifo_wr_vld = 1'b0;
    b0 = beats;
    repeat (5) begin
      step();
      chk("bp_rdy", src_rdy, 4'b0000);
    end
    chk("bp_stall_beats", beats - b0, 0);
    chk("bp_grant_held", req_grant, 4'b0100);
    fifo_wr_vld = 1'b1;
    run_until_idle(30, "bp");
    chk("bp_beats", beats, 8);

    // source stall: src_vld[2] toggles during a 4-beat burst
    req_valid = 4'b0100; req_len[2*LW +: LW] = 8'd3; src_vld = '1;
    step();
    req_valid = '0;
    beats = 0; done_cnt = 0;
    for (int k = 0; k < 12 && (m_owner >= 0 || m_done != '0); k++) begin
      src_vld[2] = (k % 2 == 0);
      step();
    end
    chk("stall_idle", busy, 1'b0);
    chk("stall_beats", beats, 4);
    chk("stall_done_cnt", done_cnt, 1);

    // reset after beat 2 of a 6-beat burst from source 1 (rotation start is 3 here)
    src_vld = '1;
    req_valid = 4'b0010; req_len[1*LW +: LW] = 8'd5;
    step();
    req_valid = '0;
    beats = 0;
    step();
    step();
    chk("rstmid_beats", beats, 2);
    src_vld = '0;
    wr_rst = 1'b1;
    step();
    wr_rst = 1'b0;
    src_vld = '1;
    #1;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_grant", req_grant, 4'b0000);
    chk("rstmid_done", burst_done, 4'b0000);
    chk("rstmid_rdy", src_rdy, 4'b0000);
    chk("rstmid_en", fifo_wr_en, 1'b0);
    chk("rstmid_rr", dbg_rr_ptr, 2'd0);
    req_valid = 4'b1010; req_len[1*LW +: LW] = 8'd1; req_len[3*LW +: LW] = 8'd1;
    step();
    chk("rstmid_next_grant", req_grant, 4'b0010);
    req_valid = '0;
    run_until_idle(10, "rstmid");

    // maximum length burst
    req_valid = 4'b0001; req_len[0*LW +: LW] = 8'd255; src_vld = '1; fifo_wr_vld = 1'b1;
    step();
    req_valid = '0;
    beats = 0; done_cnt = 0; done_or = '0;
    run_until_idle(300, "maxlen");
    chk("maxlen_beats", beats, 256);
    chk("maxlen_done_cnt", done_cnt, 1);
    chk("maxlen_done_id", done_or, 4'b0001);

    // random traffic
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && m_owner != i && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1;
          req_len[i*LW +: LW] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
        end else if (pend[i] && m_owner != i && $urandom_range(0, 63) == 0) begin
          pend[i] = 1'b0;
        end
        if (!pend[i]) req_len[i*LW +: LW] = 8'($urandom_range(0, 255));
        req_valid[i] = pend[i];
        src_vld[i]   = ($urandom_range(0, 3) != 0);
      end
      fifo_wr_vld = ($urandom_range(0, 4) != 0);
      wr_rst      = ($urandom_range(0, 999) == 0);
      if (wr_rst) for (int i = 0; i < N; i++) pend[i] = 1'b0;
      step();
      if (m_owner >= 0) pend[m_owner] = 1'b0;
    end
    wr_rst = 1'b0; req_valid = '0; src_vld = '1; fifo_wr_vld = 1'b1;
    run_until_idle(100, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/afifo_wr_arbiter.md
# afifo_wr_arbiter

Write-side scheduler for the 64-bit-in / 16-bit-out prefetch async FIFO in the ConvKing datapath. It shares the single FIFO write port between up to NUM_REQ burst sources, such as the feature loader and the weight loader. Arbitration is round-robin and burst-granular: a granted source owns the port until its whole burst has been accepted. The block lives entirely in the FIFO write-clock domain; the read side is untouched.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 64, beat width; must equal the FIFO write width
- LEN_W, 8, burst length field width; the field holds beats-1, so 1..2^LEN_W beats

Ports:
- wr_clk  in  1  write-domain clock, the only clock
- wr_rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  source i has a burst pending; held high until req_grant[i]
- req_len  in  NUM_REQ*LEN_W  beats-1 for source i; sampled at arbitration
- req_grant  out  NUM_REQ  one-hot grant, held for the whole burst
- grant_id  out  clog2(NUM_REQ)  index of the current or last grant
- src_data  in  NUM_REQ*DATA_W  beat data per source
- src_vld  in  NUM_REQ  beat valid per source
- src_rdy  out  NUM_REQ  beat accepted this cycle when src_vld & src_rdy
- fifo_wr_en  out  1  to the FIFO write enable
- fifo_wr_data  out  DATA_W  to the FIFO write data
- fifo_wr_vld  in  1  FIFO write-side ready; a beat transfers on fifo_wr_en & fifo_wr_vld
- burst_done  out  NUM_REQ  1-cycle pulse after source i's last beat
- busy  out  1  high in BURST

## Operation
- FSM has two states: IDLE and BURST.
- IDLE:
  - If any req_valid is high, pick the winner by round-robin, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - Register req_grant, grant_id, and beat_cnt = req_len[winner].
  - Go to BURST.
- BURST:
  - fifo_wr_en = src_vld[g].
  - fifo_wr_data = src_data[g].
  - src_rdy[g] = fifo_wr_vld.
  - All other src_rdy bits are 0.
  - On each accepted beat, beat_cnt decrements.
  - On the accepted beat with beat_cnt==0: clear req_grant, set rr_ptr = (g+1) mod NUM_REQ, pulse burst_done[g] in the next cycle, and return to IDLE.
- Data path is combinational mux only, with zero added latency. Outside BURST, fifo_wr_en=0 and fifo_wr_data=0.
- If src_vld is low, or fifo_wr_vld is low (FIFO full), the burst stalls indefinitely. Grant and count are held and no timeout applies.
- After grant, req_valid and req_len of the granted source are ignored until return to IDLE.
- If a source's req_valid drops before it is granted, no grant is issued to it.
- rr_ptr wraps from NUM_REQ-1 to 0.
- A single requester may win consecutive bursts when no other source is pending.

## Timing
- Reset (wr_rst high at a wr_clk edge):
  - State IDLE, rr_ptr=0, beat_cnt=0.
  - req_grant=0, grant_id=0, src_rdy=0, fifo_wr_en=0, fifo_wr_data=0, burst_done=0, busy=0.
- Reset mid-burst drops the grant immediately and the partial burst is lost. The integrator resets the FIFO on the same wr_rst.
- Arbitration latency: req_valid high in an IDLE cycle t gives req_grant and busy high at t+1. The first beat may transfer at t+1.
- Burst turnaround: last beat accepted at cycle t, then IDLE at t+1, next grant at t+2. This is exactly one bubble cycle, and burst_done is high at t+1.
- Peak throughput for an N-beat burst: N beats in N+1 cycles.

## Configuration
- CONVKING_ARB_REQ0_PRIO_EN defined: requester 0 wins every arbitration in which req_valid[0] is high, regardless of rr_ptr. rr_ptr is not updated when requester 0 wins by priority. Other sources keep round-robin among themselves.
- CONVKING_ARB_REQ0_PRIO_EN undefined: pure round-robin for all sources, including 0.

## Test plan
- Single burst: req_valid[1]=1, req_len=3, src_vld[1] always high, fifo_wr_vld=1.
  - req_grant=4'b0010 one cycle later.
  - Exactly 4 fifo_wr_en beats.
  - burst_done[1] pulses once.
  - busy low on the following cycle.
- Round-robin: all four req_valid high, req_len=0.
  - Grants in order 0,1,2,3,0.
  - One bubble between grants.
  - With CONVKING_ARB_REQ0_PRIO_EN, the order is 0,0,0... while req_valid[0] is held.
- Backpressure: fifo_wr_vld low for 5 cycles mid-burst of 8.
  - src_rdy and transfers stop.
  - Grant held.
  - Total accepted beats still 8 with data order preserved.
- Source stall: src_vld[2] toggling 1,0,1,0 during a burst of 4.
  - fifo_wr_en follows src_vld.
  - Burst completes after 4 accepted beats.
- Reset mid-burst: wr_rst high after beat 2 of 6.
  - All outputs at reset values next cycle.
  - rr_ptr=0, so the next grant goes to the lowest pending index.
- Max length: req_len=255.
  - Exactly 256 beats, then burst_done.
  - No counter wrap or extra beat.
